// File: rtl/cart_rom_arbiter_pkg.sv
// Shared constants and FSM encoding for the cartridge ROM port arbiter.
package cart_rom_arbiter_pkg;

   localparam int CART_ADDR_W = 16;
   localparam int CART_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } cart_state_t;

   // Value returned when no cartridge answers, matching an undriven bus.
   localparam logic [CART_DATA_W-1:0] CART_OPEN_BUS = 8'hFF;

   localparam logic [CART_ADDR_W-1:0] LOGO_START = 16'h0104;
   localparam logic [CART_ADDR_W-1:0] LOGO_END   = 16'h0133;

endpackage

// File: rtl/cart_rom_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first pending port after the pointer wins.
module rr_arbiter
   import cart_rom_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
)
(
   input  logic [NUM_REQ-1:0] i_pending,
   input  logic [1:0]         i_pointer,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [1:0]         o_index,
   output logic               o_valid
);

   int w_rank;
   int w_bestRank;

   // Rank 0 is the port right after the pointer; the lowest-ranked pending port wins.
   always_comb begin
      o_grant    = '0;
      o_index    = '0;
      w_rank     = 0;
      w_bestRank = NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
         w_rank = (j + 2 * NUM_REQ - int'(i_pointer) - 1) % NUM_REQ;
         if (i_pending[j] && (w_rank < w_bestRank)) begin
            w_bestRank = w_rank;
            o_grant    = '0;
            o_grant[j] = 1'b1;
            o_index    = 2'(j);
         end
      end
      o_valid = |i_pending;
   end

endmodule

// File: rtl/cart_rom_arbiter.sv
// Shares one cartridge ROM read port between NUM_REQ rd/bsy clients, one access at a time.
// Optional CART_ROM_TIMEOUT_EN: abandon a stuck access after TIMEOUT_CYCLES and return open-bus data.
module cart_rom_arbiter
   import cart_rom_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
)
(
   input  logic                           clk_8m,
   input  logic                           rst,
   input  logic [CART_ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [NUM_REQ-1:0]             req_rd,
   output logic [NUM_REQ-1:0]             req_bsy,
   output logic [CART_DATA_W*NUM_REQ-1:0] req_data,
   output logic [CART_ADDR_W-1:0]         rom_addr,
   output logic                           rom_rd,
   input  logic                           rom_bsy,
   input  logic [CART_DATA_W-1:0]         rom_data,
   output logic [1:0]                     grant_id,
   output logic                           rom_timeout
);

   if ((NUM_REQ < 1) || (NUM_REQ > 4)) begin : g_badNumReq
      $error("cart_rom_arbiter: NUM_REQ must be 1..4");
   end
   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_badTimeout
      $error("cart_rom_arbiter: TIMEOUT_CYCLES must fit the 16-bit wait counter");
   end

   cart_state_t                    r_state;
   cart_state_t                    w_nextState;
   logic [NUM_REQ-1:0]             r_pending;
   logic [CART_ADDR_W*NUM_REQ-1:0] r_addr;
   logic [CART_DATA_W*NUM_REQ-1:0] r_reqData;
   logic [CART_ADDR_W-1:0]         r_romAddr;
   logic [CART_ADDR_W-1:0]         w_selAddr;
   logic [1:0]                     r_ptr;
   logic [1:0]                     r_grantId;
   logic [NUM_REQ-1:0]             w_grantOneHot;
   logic [1:0]                     w_grantIdx;
   logic                           w_grantValid;
   logic                           w_load;
   logic                           w_done;
   logic                           w_expire;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .i_pending (r_pending),
      .i_pointer (r_ptr),
      .o_grant   (w_grantOneHot),
      .o_index   (w_grantIdx),
      .o_valid   (w_grantValid)
   );

   always_comb begin
      w_selAddr = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_grantOneHot[j]) begin
            w_selAddr = w_selAddr | r_addr[CART_ADDR_W*j +: CART_ADDR_W];
         end
      end
   end

   always_ff @(posedge clk_8m) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A stuck access only leaves WAIT early through the optional timeout.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grantValid) begin
               w_load      = 1'b1;
               w_nextState = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_nextState = ST_WAIT;
         end
         ST_WAIT: begin
            if (!rom_bsy || w_expire) begin
               w_done      = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_8m) begin
      if (rst) begin
         r_romAddr <= '0;
         r_grantId <= '0;
         r_ptr     <= 2'(NUM_REQ - 1);
      end else begin
         if (w_load) begin
            r_grantId <= w_grantIdx;
            r_romAddr <= w_selAddr;
         end
         if (w_done) begin
            r_ptr <= r_grantId;
         end
      end
   end

   // A strobe from a port that is still pending is dropped, keeping its first address.
   always_ff @(posedge clk_8m) begin
      if (rst) begin
         r_pending <= '0;
         r_addr    <= '0;
         r_reqData <= '0;
      end else begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (req_rd[j] && !r_pending[j]) begin
               r_pending[j]                         <= 1'b1;
               r_addr[CART_ADDR_W*j +: CART_ADDR_W] <= req_addr[CART_ADDR_W*j +: CART_ADDR_W];
            end else if (w_done && (r_grantId == 2'(j))) begin
               r_pending[j]                            <= 1'b0;
               r_reqData[CART_DATA_W*j +: CART_DATA_W] <= w_expire ? CART_OPEN_BUS : rom_data;
            end
         end
      end
   end

`ifdef CART_ROM_TIMEOUT_EN
   logic [15:0] r_waitCnt;
   logic        r_timeout;

   always_ff @(posedge clk_8m) begin
      if (rst) begin
         r_waitCnt <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (r_state == ST_WAIT) begin
            r_waitCnt <= r_waitCnt + 16'd1;
         end else begin
            r_waitCnt <= '0;
         end
      end
   end

   assign w_expire    = (r_state == ST_WAIT) && rom_bsy && (r_waitCnt == 16'(TIMEOUT_CYCLES - 1));
   assign rom_timeout = r_timeout;
`else
   assign w_expire    = 1'b0;
   assign rom_timeout = 1'b0;
`endif

   assign rom_rd   = (r_state == ST_ISSUE);
   assign rom_addr = r_romAddr;
   assign grant_id = r_grantId;
   assign req_bsy  = r_pending;
   assign req_data = r_reqData;

endmodule
